// File: rtl/bp_update_scheduler.sv
// Branch-predictor update scheduler: queues resolved-branch updates from two lanes
// and issues up to two per cycle, oldest first, holding back same-index pairs.
module bp_update_scheduler #(
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          V_IN1,
  input  logic [31:0]   PC_IN1,
  input  logic [31:0]   TGT_IN1,
  input  logic          TK_IN1,
  input  logic          COND_IN1,
  input  logic          WTGT_IN1,
  input  logic          V_IN2,
  input  logic [31:0]   PC_IN2,
  input  logic [31:0]   TGT_IN2,
  input  logic          TK_IN2,
  input  logic          COND_IN2,
  input  logic          WTGT_IN2,
  output logic          IN_READY,
  output logic          WE1,
  output logic          WE2,
  output logic          US1,
  output logic          US2,
  output logic          T1,
  output logic          T2,
  output logic [31:0]   WA1,
  output logic [31:0]   WA2,
  output logic [31:0]   WD1,
  output logic [31:0]   WD2,
  output logic [CW-1:0] COUNT,
  output logic          OVF
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        tk;
    logic        cond;
    logic        wtgt;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW-1:0] head1, tail1;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] enq_n, deq_n;
  logic          ovf_q, ovf_d;
  logic          in_ready, h0_valid, h1_valid, conflict;
  logic          iss1, iss2, wr0_en, wr1_en;
  entry_t        lane1, lane2, wr0_data, h0, h1;

  assign lane1 = {PC_IN1, TGT_IN1, TK_IN1, COND_IN1, WTGT_IN1};
  assign lane2 = {PC_IN2, TGT_IN2, TK_IN2, COND_IN2, WTGT_IN2};

  always_comb begin
    head1    = head_q + AW'(1);
    tail1    = tail_q + AW'(1);
    h0       = mem_q[head_q];
    h1       = mem_q[head1];
    // Readiness looks only at registered occupancy, never at this cycle's drain.
    in_ready = (count_q <= CW'(DEPTH - 2));
    h0_valid = (count_q != '0);
    h1_valid = (count_q >= CW'(2));
    conflict = (h0.pc[13:2] == h1.pc[13:2]);
    iss1     = h0_valid;
    iss2     = h1_valid && !conflict;

    wr0_en   = in_ready && (V_IN1 || V_IN2);
    wr1_en   = in_ready && V_IN1 && V_IN2;
    wr0_data = V_IN1 ? lane1 : lane2;

    enq_n    = CW'(wr0_en) + CW'(wr1_en);
    deq_n    = CW'(iss1) + CW'(iss2);
    head_d   = head_q + AW'(deq_n);
    tail_d   = tail_q + AW'(enq_n);
    count_d  = count_q + enq_n - deq_n;
    ovf_d    = ovf_q || (!in_ready && (V_IN1 || V_IN2));
  end

  always_comb begin
    WE1 = 1'b0;
    US1 = 1'b0;
    T1  = 1'b0;
    WA1 = '0;
    WD1 = '0;
    WE2 = 1'b0;
    US2 = 1'b0;
    T2  = 1'b0;
    WA2 = '0;
    WD2 = '0;
    if (iss1) begin
      WE1 = h0.wtgt;
      US1 = h0.cond;
      T1  = h0.tk;
      WA1 = h0.pc;
      WD1 = h0.tgt;
    end
    if (iss2) begin
      WE2 = h1.wtgt;
      US2 = h1.cond;
      T2  = h1.tk;
      WA2 = h1.pc;
      WD2 = h1.tgt;
    end
  end

  assign IN_READY = in_ready;
  assign COUNT    = count_q;
  assign OVF      = ovf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Payload storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (wr0_en) mem_q[tail_q] <= wr0_data;
    if (wr1_en) mem_q[tail1]  <= lane2;
  end

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Bench for bp_update_scheduler: directed table, multi-cycle corner sequences
// and random traffic checked against a queue-based reference model.
module tb_bp_update_scheduler;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic v1, tk1, cond1, wtgt1, v2, tk2, cond2, wtgt2;
  logic [31:0] pc1, tgt1, pc2, tgt2;
  logic IN_READY, WE1, WE2, US1, US2, T1, T2, OVF;
  logic [31:0] WA1, WA2, WD1, WD2;
  logic [CW-1:0] COUNT;

  bp_update_scheduler #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .V_IN1(v1), .PC_IN1(pc1), .TGT_IN1(tgt1), .TK_IN1(tk1), .COND_IN1(cond1), .WTGT_IN1(wtgt1),
    .V_IN2(v2), .PC_IN2(pc2), .TGT_IN2(tgt2), .TK_IN2(tk2), .COND_IN2(cond2), .WTGT_IN2(wtgt2),
    .IN_READY(IN_READY), .WE1(WE1), .WE2(WE2), .US1(US1), .US2(US2), .T1(T1), .T2(T2),
    .WA1(WA1), .WA2(WA2), .WD1(WD1), .WD2(WD2), .COUNT(COUNT), .OVF(OVF)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        tk;
    logic        cond;
    logic        wtgt;
  } ent_t;

  ent_t mq[$];
  logic movf = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  typedef struct packed {
    logic v1; logic [31:0] pc1; logic [31:0] tgt1; logic tk1; logic c1; logic w1;
    logic v2; logic [31:0] pc2; logic [31:0] tgt2; logic tk2; logic c2; logic w2;
    logic e_we1; logic e_us1; logic e_t1; logic [31:0] e_wa1; logic [31:0] e_wd1;
    logic e_we2; logic e_us2; logic e_t2; logic [31:0] e_wa2; logic [31:0] e_wd2;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected outputs straight from the issue rules applied to the oldest two queued updates.
  task automatic check_model();
    ent_t e0, e1;
    e0 = '{32'd0, 32'd0, 1'b0, 1'b0, 1'b0};
    e1 = '{32'd0, 32'd0, 1'b0, 1'b0, 1'b0};
    if (mq.size() >= 1) e0 = mq[0];
    if (mq.size() >= 2 && mq[0].pc[13:2] != mq[1].pc[13:2]) e1 = mq[1];
    chk("WE1", WE1, e0.wtgt);
    chk("US1", US1, e0.cond);
    chk("T1", T1, e0.tk);
    chk("WA1", WA1, e0.pc);
    chk("WD1", WD1, e0.tgt);
    chk("WE2", WE2, e1.wtgt);
    chk("US2", US2, e1.cond);
    chk("T2", T2, e1.tk);
    chk("WA2", WA2, e1.pc);
    chk("WD2", WD2, e1.tgt);
    chk("COUNT", COUNT, mq.size());
    chk("IN_READY", IN_READY, mq.size() <= DEPTH - 2);
    chk("OVF", OVF, movf);
  endtask

  task automatic model_edge();
    int deq;
    bit rdy;
    deq = 0;
    if (mq.size() >= 1) deq = 1;
    if (mq.size() >= 2 && mq[0].pc[13:2] != mq[1].pc[13:2]) deq = 2;
    rdy = (mq.size() <= DEPTH - 2);
    repeat (deq) void'(mq.pop_front());
    if (rdy) begin
      if (v1) mq.push_back('{pc1, tgt1, tk1, cond1, wtgt1});
      if (v2) mq.push_back('{pc2, tgt2, tk2, cond2, wtgt2});
    end else if (v1 || v2) begin
      movf = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_in();
    v1 = 0; pc1 = 0; tgt1 = 0; tk1 = 0; cond1 = 0; wtgt1 = 0;
    v2 = 0; pc2 = 0; tgt2 = 0; tk2 = 0; cond2 = 0; wtgt2 = 0;
  endtask

  task automatic set1(input logic [31:0] pc, input logic [31:0] tgt, input logic tk, input logic c, input logic w);
    v1 = 1; pc1 = pc; tgt1 = tgt; tk1 = tk; cond1 = c; wtgt1 = w;
  endtask

  task automatic set2(input logic [31:0] pc, input logic [31:0] tgt, input logic tk, input logic c, input logic w);
    v2 = 1; pc2 = pc; tgt2 = tgt; tk2 = tk; cond2 = c; wtgt2 = w;
  endtask

  task automatic do_reset();
    reset = 0;
    idle_in();
    mq.delete();
    movf = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1;
  endtask

  task automatic r_in1(input int i, input logic [31:0] pc, input logic [31:0] tgt, input logic tk, input logic c, input logic w);
    tbl[i].v1 = 1; tbl[i].pc1 = pc; tbl[i].tgt1 = tgt; tbl[i].tk1 = tk; tbl[i].c1 = c; tbl[i].w1 = w;
  endtask

  task automatic r_in2(input int i, input logic [31:0] pc, input logic [31:0] tgt, input logic tk, input logic c, input logic w);
    tbl[i].v2 = 1; tbl[i].pc2 = pc; tbl[i].tgt2 = tgt; tbl[i].tk2 = tk; tbl[i].c2 = c; tbl[i].w2 = w;
  endtask

  task automatic r_p1(input int i, input logic we, input logic us, input logic t, input logic [31:0] wa, input logic [31:0] wd);
    tbl[i].e_we1 = we; tbl[i].e_us1 = us; tbl[i].e_t1 = t; tbl[i].e_wa1 = wa; tbl[i].e_wd1 = wd;
  endtask

  task automatic r_p2(input int i, input logic we, input logic us, input logic t, input logic [31:0] wa, input logic [31:0] wd);
    tbl[i].e_we2 = we; tbl[i].e_us2 = us; tbl[i].e_t2 = t; tbl[i].e_wa2 = wa; tbl[i].e_wd2 = wd;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int issued;
    int k;
    bit got;
    logic [31:0] rp;

    idle_in();
    for (int i = 0; i < 10; i++) tbl[i] = '0;
    // single update, then idle
    r_in1(0, 32'h40, 32'h100, 1, 1, 1);
    r_p1(1, 1, 1, 1, 32'h40, 32'h100);  tbl[1].e_cnt = 1;
    // dual non-conflicting
    r_in1(3, 32'h40, 32'h200, 0, 1, 0);
    r_in2(3, 32'h80, 32'h300, 1, 1, 1);
    r_p1(4, 0, 1, 0, 32'h40, 32'h200);
    r_p2(4, 1, 1, 1, 32'h80, 32'h300);  tbl[4].e_cnt = 2;
    // dual conflicting (same [13:2])
    r_in1(6, 32'h40, 32'h500, 1, 1, 1);
    r_in2(6, 32'h4040, 32'h600, 1, 1, 1);
    r_p1(7, 1, 1, 1, 32'h40, 32'h500);  tbl[7].e_cnt = 2;
    r_p1(8, 1, 1, 1, 32'h4040, 32'h600); tbl[8].e_cnt = 1;

    @(negedge clk);
    do_reset();
    chk("reset_IN_READY", IN_READY, 1);
    chk("reset_COUNT", COUNT, 0);
    chk("reset_OVF", OVF, 0);

    for (int i = 0; i < 10; i++) begin
      v1 = tbl[i].v1; pc1 = tbl[i].pc1; tgt1 = tbl[i].tgt1; tk1 = tbl[i].tk1; cond1 = tbl[i].c1; wtgt1 = tbl[i].w1;
      v2 = tbl[i].v2; pc2 = tbl[i].pc2; tgt2 = tbl[i].tgt2; tk2 = tbl[i].tk2; cond2 = tbl[i].c2; wtgt2 = tbl[i].w2;
      chk($sformatf("tbl%0d_WE1", i), WE1, tbl[i].e_we1);
      chk($sformatf("tbl%0d_US1", i), US1, tbl[i].e_us1);
      chk($sformatf("tbl%0d_T1", i), T1, tbl[i].e_t1);
      chk($sformatf("tbl%0d_WA1", i), WA1, tbl[i].e_wa1);
      chk($sformatf("tbl%0d_WD1", i), WD1, tbl[i].e_wd1);
      chk($sformatf("tbl%0d_WE2", i), WE2, tbl[i].e_we2);
      chk($sformatf("tbl%0d_US2", i), US2, tbl[i].e_us2);
      chk($sformatf("tbl%0d_T2", i), T2, tbl[i].e_t2);
      chk($sformatf("tbl%0d_WA2", i), WA2, tbl[i].e_wa2);
      chk($sformatf("tbl%0d_WD2", i), WD2, tbl[i].e_wd2);
      chk($sformatf("tbl%0d_COUNT", i), COUNT, tbl[i].e_cnt);
      step();
    end
    idle_in();

    // Mid-cycle reset with a partly full queue of mutually conflicting entries
    for (int i = 0; i < 4; i++) begin
      set1(32'h1000 + i * 32'h8000, 32'hA0 + i, 1, 1, 1);
      set2(32'h5000 + i * 32'h8000, 32'hB0 + i, 0, 1, 0);
      check_model();
      step();
    end
    idle_in();
    chk("prereset_COUNT", COUNT, 5);
    #2 reset = 0;
    mq.delete();
    movf = 0;
    #1;
    chk("rst_WE1", WE1, 0);
    chk("rst_US1", US1, 0);
    chk("rst_WA1", WA1, 0);
    chk("rst_WD1", WD1, 0);
    chk("rst_COUNT", COUNT, 0);
    @(negedge clk);
    reset = 1;
    chk("rst_release_IN_READY", IN_READY, 1);
    for (int i = 0; i < 4; i++) begin
      check_model();
      step();
    end

    // Fill with conflicting pairs until not ready, drop one, drain across the wrap
    k = 0;
    got = 0;
    for (int i = 0; i < 12; i++) begin
      if (!IN_READY) begin
        got = 1;
        break;
      end
      set1(32'h40 + k * 32'h4000, 32'h1000 + k, k[0], 1, 1);
      k++;
      set2(32'h40 + k * 32'h4000, 32'h1000 + k, k[0], 1, 0);
      k++;
      check_model();
      step();
    end
    idle_in();
    chk("fill_ready_deasserts", got, 1);
    chk("fill_count_ge7", COUNT >= 7, 1);
    check_model();
    set1(32'hDEAD_0040, 32'hDEAD, 1, 1, 1);
    step();
    idle_in();
    chk("drop_sets_OVF", OVF, 1);
    for (int i = 0; i < 12; i++) begin
      check_model();
      step();
    end
    chk("drain_empty_COUNT", COUNT, 0);
    chk("ovf_sticky", OVF, 1);

    // Steady state dual enqueue of non-conflicting pairs
    do_reset();
    issued = 0;
    for (int i = 0; i < 20; i++) begin
      set1(32'h2000 + i * 8, 32'h3000 + i, 1, 1, 1);
      set2(32'h2004 + i * 8, 32'h4000 + i, 0, 1, 1);
      check_model();
      chk("steady_count_le2", COUNT <= 2, 1);
      issued += int'(US1) + int'(US2);
      step();
    end
    idle_in();
    for (int i = 0; i < 3; i++) begin
      check_model();
      issued += int'(US1) + int'(US2);
      step();
    end
    chk("steady_issued", issued, 40);
    chk("steady_OVF", OVF, 0);

    // Random traffic with frequent index collisions
    do_reset();
    for (int i = 0; i < 400; i++) begin
      idle_in();
      if ($urandom_range(0, 3) != 0) begin
        rp = ($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, 3)) << 2);
        set1(rp, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
      end
      if ($urandom_range(0, 3) != 0) begin
        rp = ($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, 3)) << 2);
        set2(rp, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
      end
      check_model();
      step();
    end
    idle_in();
    for (int i = 0; i < 10; i++) begin
      check_model();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
